// File: rtl/ccd_line_timing_gen.sv
// ---------------------------------------------------------------------------
// ccd_line_timing_gen
//
// Timing generator for linear CCD sensors (ILX511B class). Produces the ROG
// integration window, the CCD pixel clock and one ADC start strobe per pixel.
// It supports single-shot or free-running frames and can be aborted.
//
// Frame sequence:
//   IDLE -> INTEG (ROG low) -> ROG_DLY -> READOUT -> FRAME_END -> IDLE/INTEG
//
// Ports:
//   sys_clk      system clock
//   sys_rst      asynchronous, active-high reset
//   acq_start    acquisition request (level, rising edge starts a frame)
//   mode_cont    1 = continuous frames, 0 = single shot (sampled at frame end)
//   abort        synchronous abort, returns to IDLE on the next cycle
//   int_ticks    integration time in ticks of TICK_DIV cycles (0 acts as 1)
//   ccd_rog      ROG gate, low during integration, idles high
//   ccd_clk      CCD pixel clock, idles high
//   adc_start    one-cycle strobe per pixel
//   pix_idx      pixel being strobed, valid while adc_start = 1
//   adc_restart  one-cycle pulse at every integration start
//   frame_done   one-cycle pulse after the last pixel period
//   busy         high whenever the generator is not IDLE
// ---------------------------------------------------------------------------
module ccd_line_timing_gen #(
  parameter int TICK_DIV   = 100000,
  parameter int INT_W      = 16,
  parameter int PIX_COUNT  = 2087,
  parameter int PIX_W      = 12,
  parameter int HALF_PER   = 8,
  parameter int ROG_DELAY  = 100,
  parameter int ADC_OFFSET = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             acq_start,
  input  logic             mode_cont,
  input  logic             abort,
  input  logic [INT_W-1:0] int_ticks,
  output logic             ccd_rog,
  output logic             ccd_clk,
  output logic             adc_start,
  output logic [PIX_W-1:0] pix_idx,
  output logic             adc_restart,
  output logic             frame_done,
  output logic             busy
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_W  = (ROG_DELAY > 1) ? $clog2(ROG_DELAY) : 1;
  localparam int PH_W   = $clog2(2 * HALF_PER);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(ROG_DELAY - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * HALF_PER - 1);
  localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(HALF_PER);
  localparam logic [PH_W-1:0]   PH_ADC    = PH_W'(ADC_OFFSET);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_COUNT - 1);
  localparam logic [INT_W-1:0]  INT_ONE   = INT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    INTEG,
    ROG_DLY,
    READOUT,
    FRAME_END
  } state_t;

  state_t            state;
  logic              acq_start_q;
  logic [INT_W-1:0]  int_lat;
  logic [TICK_W-1:0] tick_cnt;
  logic [INT_W-1:0]  tick_num;
  logic [DLY_W-1:0]  dly_cnt;
  logic [PH_W-1:0]   phase_cnt;

  logic              start_edge;
  logic [INT_W-1:0]  int_eff;
  logic [INT_W-1:0]  tick_nxt;
  logic              phase_last;
  logic [PH_W-1:0]   phase_nxt;
  logic [PIX_W-1:0]  pix_nxt;

  assign start_edge = acq_start & ~acq_start_q;
  // A zero integration request still produces one full tick of ROG low.
  assign int_eff    = (int_ticks == '0) ? INT_ONE : int_ticks;
  assign tick_nxt   = tick_num + INT_ONE;
  assign phase_last = (phase_cnt == PH_LAST);
  assign phase_nxt  = phase_last ? '0 : phase_cnt + PH_W'(1);
  assign pix_nxt    = phase_last ? pix_idx + PIX_W'(1) : pix_idx;

  // Single FSM with registered outputs. Output registers are loaded with the
  // value for the cycle being entered, so ccd_clk and ccd_rog come straight
  // from flops and cannot glitch. The strobes default low every cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      acq_start_q <= 1'b0;
      int_lat     <= '0;
      tick_cnt    <= '0;
      tick_num    <= '0;
      dly_cnt     <= '0;
      phase_cnt   <= '0;
      pix_idx     <= '0;
      ccd_rog     <= 1'b1;
      ccd_clk     <= 1'b1;
      adc_start   <= 1'b0;
      adc_restart <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      acq_start_q <= acq_start;
      adc_start   <= 1'b0;
      adc_restart <= 1'b0;
      frame_done  <= 1'b0;

      if (abort) begin
        state     <= IDLE;
        tick_cnt  <= '0;
        tick_num  <= '0;
        dly_cnt   <= '0;
        phase_cnt <= '0;
        pix_idx   <= '0;
        ccd_rog   <= 1'b1;
        ccd_clk   <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              state       <= INTEG;
              int_lat     <= int_eff;
              tick_cnt    <= '0;
              tick_num    <= '0;
              ccd_rog     <= 1'b0;
              adc_restart <= 1'b1;
              busy        <= 1'b1;
            end
          end

          // ROG stays low until int_lat whole ticks have elapsed.
          INTEG: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              tick_num <= tick_nxt;
              if (tick_nxt == int_lat) begin
                state   <= ROG_DLY;
                dly_cnt <= '0;
                ccd_rog <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end

          // The last delay cycle pre-loads the first low phase of pixel 0.
          ROG_DLY: begin
            if (dly_cnt == DLY_LAST) begin
              state     <= READOUT;
              dly_cnt   <= '0;
              phase_cnt <= '0;
              pix_idx   <= '0;
              ccd_clk   <= 1'b0;
              adc_start <= (PH_ADC == '0);
            end else begin
              dly_cnt <= dly_cnt + DLY_W'(1);
            end
          end

          // phase_cnt tracks the current cycle in the pixel period; the
          // outputs are driven from the phase of the following cycle.
          READOUT: begin
            if (phase_last && (pix_idx == PIX_LAST)) begin
              state      <= FRAME_END;
              phase_cnt  <= '0;
              pix_idx    <= '0;
              ccd_clk    <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              phase_cnt <= phase_nxt;
              pix_idx   <= pix_nxt;
              ccd_clk   <= (phase_nxt >= PH_HIGH);
              adc_start <= (phase_nxt == PH_ADC);
            end
          end

          // frame_done is visible here; mode_cont decides what follows.
          FRAME_END: begin
            if (mode_cont) begin
              state       <= INTEG;
              int_lat     <= int_eff;
              tick_cnt    <= '0;
              tick_num    <= '0;
              ccd_rog     <= 1'b0;
              adc_restart <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state   <= IDLE;
            ccd_rog <= 1'b1;
            ccd_clk <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccd_line_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_ccd_line_timing_gen
//
// Directed bench for ccd_line_timing_gen with TICK_DIV=10, HALF_PER=2,
// PIX_COUNT=4, ROG_DELAY=3, ADC_OFFSET=1. Each scenario starts a frame at a
// falling edge (cycle index 0), records the outputs at every following
// falling edge into trace arrays and compares extracted event positions
// against hand-computed cycle numbers.
// ---------------------------------------------------------------------------
module tb_ccd_line_timing_gen;

  localparam int INT_W = 8;
  localparam int PIX_W = 4;
  localparam int MAXC  = 128;

  logic             sys_clk;
  logic             sys_rst;
  logic             acq_start;
  logic             mode_cont;
  logic             abort;
  logic [INT_W-1:0] int_ticks;
  logic             ccd_rog;
  logic             ccd_clk;
  logic             adc_start;
  logic [PIX_W-1:0] pix_idx;
  logic             adc_restart;
  logic             frame_done;
  logic             busy;

  int tests_run;
  int tests_failed;

  logic             tr_rog     [0:MAXC-1];
  logic             tr_clk     [0:MAXC-1];
  logic             tr_adc     [0:MAXC-1];
  logic [PIX_W-1:0] tr_pix     [0:MAXC-1];
  logic             tr_restart [0:MAXC-1];
  logic             tr_done    [0:MAXC-1];
  logic             tr_busy    [0:MAXC-1];

  int rog_low_cnt, rog_first, rog_last, clk_fall;
  int rst_cnt, adc_cnt, done_cnt, busy_cnt;
  int rst_pos  [0:7];
  int adc_pos  [0:7];
  int adc_pix  [0:7];
  int done_pos [0:7];

  ccd_line_timing_gen #(
    .TICK_DIV  (10),
    .INT_W     (INT_W),
    .PIX_COUNT (4),
    .PIX_W     (PIX_W),
    .HALF_PER  (2),
    .ROG_DELAY (3),
    .ADC_OFFSET(1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .acq_start  (acq_start),
    .mode_cont  (mode_cont),
    .abort      (abort),
    .int_ticks  (int_ticks),
    .ccd_rog    (ccd_rog),
    .ccd_clk    (ccd_clk),
    .adc_start  (adc_start),
    .pix_idx    (pix_idx),
    .adc_restart(adc_restart),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drives a start edge at the next falling edge (this is cycle index 0).
  task automatic applyStimulus(input int ticks, input logic mode, input logic with_abort);
    @(negedge sys_clk);
    int_ticks = INT_W'(ticks);
    mode_cont = mode;
    acq_start = 1'b1;
    abort     = with_abort;
  endtask

  task automatic recordAt(input int k);
    tr_rog[k]     = ccd_rog;
    tr_clk[k]     = ccd_clk;
    tr_adc[k]     = adc_start;
    tr_pix[k]     = pix_idx;
    tr_restart[k] = adc_restart;
    tr_done[k]    = frame_done;
    tr_busy[k]    = busy;
  endtask

  // Records n cycles. After sampling cycle k the inputs for the clock edge
  // ending cycle k are set: abort pulses at abort_at, acq_start pulses at
  // reedge_at, mode_cont clears at clr_at.
  task automatic captureCycles(input int n, input int clr_at, input int abort_at, input int reedge_at);
    recordAt(0);
    for (int k = 1; k <= n; k++) begin
      @(negedge sys_clk);
      recordAt(k);
      abort     = (k == abort_at);
      acq_start = (k == reedge_at);
      if (k == clr_at) mode_cont = 1'b0;
    end
  endtask

  task automatic analyze(input int n);
    rog_low_cnt = 0; rog_first = -1; rog_last = -1; clk_fall = -1;
    rst_cnt = 0; adc_cnt = 0; done_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      if (!tr_rog[k]) begin
        rog_low_cnt++;
        if (rog_first < 0) rog_first = k;
        rog_last = k;
      end
      if (clk_fall < 0 && !tr_clk[k] && tr_clk[k-1]) clk_fall = k;
      if (tr_restart[k]) begin
        if (rst_cnt < 8) rst_pos[rst_cnt] = k;
        rst_cnt++;
      end
      if (tr_adc[k]) begin
        if (adc_cnt < 8) begin
          adc_pos[adc_cnt] = k;
          adc_pix[adc_cnt] = int'(tr_pix[k]);
        end
        adc_cnt++;
      end
      if (tr_done[k]) begin
        if (done_cnt < 8) done_pos[done_cnt] = k;
        done_cnt++;
      end
      if (tr_busy[k]) busy_cnt++;
    end
  endtask

  // Checks a complete single-shot frame whose ROG window is rog_len cycles.
  task automatic checkSingleFrame(input string sc, input int rog_len);
    checkOutput({sc, " rog_low_cnt"}, 32'(rog_low_cnt), 32'(rog_len));
    checkOutput({sc, " rog_first"}, 32'(rog_first), 32'd1);
    checkOutput({sc, " rog_last"}, 32'(rog_last), 32'(rog_len));
    checkOutput({sc, " restart_cnt"}, 32'(rst_cnt), 32'd1);
    checkOutput({sc, " restart_pos"}, 32'(rst_pos[0]), 32'd1);
    checkOutput({sc, " clk_first_fall"}, 32'(clk_fall), 32'(rog_len + 4));
    checkOutput({sc, " adc_cnt"}, 32'(adc_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput({sc, " adc_pos"}, 32'(adc_pos[i]), 32'(rog_len + 5 + 4 * i));
      checkOutput({sc, " adc_pix"}, 32'(adc_pix[i]), 32'(i));
    end
    checkOutput({sc, " done_cnt"}, 32'(done_cnt), 32'd1);
    checkOutput({sc, " done_pos"}, 32'(done_pos[0]), 32'(rog_len + 20));
    checkOutput({sc, " busy_at_done"}, 32'(tr_busy[rog_len + 20]), 32'd1);
    checkOutput({sc, " busy_after"}, 32'(tr_busy[rog_len + 21]), 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    sys_rst      = 1'b1;
    acq_start    = 1'b0;
    mode_cont    = 1'b0;
    abort        = 1'b0;
    int_ticks    = '0;

    #2;
    checkOutput("reset rog", 32'(ccd_rog), 32'd1);
    checkOutput("reset clk", 32'(ccd_clk), 32'd1);
    checkOutput("reset adc_start", 32'(adc_start), 32'd0);
    checkOutput("reset pix_idx", 32'(pix_idx), 32'd0);
    checkOutput("reset restart", 32'(adc_restart), 32'd0);
    checkOutput("reset done", 32'(frame_done), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Scenario 1: single shot, 3 ticks -> 30 ROG-low cycles.
    applyStimulus(3, 1'b0, 1'b0);
    captureCycles(60, -1, -1, -1);
    analyze(60);
    checkSingleFrame("s1", 30);

    // Scenario 2: int_ticks = 0 behaves as one tick.
    applyStimulus(0, 1'b0, 1'b0);
    captureCycles(40, -1, -1, -1);
    analyze(40);
    checkSingleFrame("s2", 10);

    // Scenario 3: continuous, 2 ticks -> 40-cycle frames; stop in frame 2.
    applyStimulus(2, 1'b1, 1'b0);
    captureCycles(100, 50, -1, -1);
    analyze(100);
    checkOutput("s3 rog_low_cnt", 32'(rog_low_cnt), 32'd40);
    checkOutput("s3 restart_cnt", 32'(rst_cnt), 32'd2);
    checkOutput("s3 restart_pos0", 32'(rst_pos[0]), 32'd1);
    checkOutput("s3 restart_pos1", 32'(rst_pos[1]), 32'd41);
    checkOutput("s3 done_cnt", 32'(done_cnt), 32'd2);
    checkOutput("s3 done_pos0", 32'(done_pos[0]), 32'd40);
    checkOutput("s3 done_pos1", 32'(done_pos[1]), 32'd80);
    checkOutput("s3 clk_first_fall", 32'(clk_fall), 32'd24);
    checkOutput("s3 adc_cnt", 32'(adc_cnt), 32'd8);
    checkOutput("s3 adc_pos4", 32'(adc_pos[4]), 32'd65);
    checkOutput("s3 adc_pix4", 32'(adc_pix[4]), 32'd0);
    checkOutput("s3 adc_pos7", 32'(adc_pos[7]), 32'd77);
    checkOutput("s3 busy_gap", 32'(busy_cnt), 32'd80);
    checkOutput("s3 rog_frame2_start", 32'(tr_rog[41]), 32'd0);
    checkOutput("s3 busy_after", 32'(tr_busy[81]), 32'd0);

    // Scenario 4: abort while pixel 2 is strobed (cycle 23 with 1 tick).
    applyStimulus(1, 1'b0, 1'b0);
    captureCycles(40, -1, 23, -1);
    analyze(40);
    checkOutput("s4 pix_at_abort", 32'(tr_pix[23]), 32'd2);
    checkOutput("s4 clk_after", 32'(tr_clk[24]), 32'd1);
    checkOutput("s4 rog_after", 32'(tr_rog[24]), 32'd1);
    checkOutput("s4 busy_after", 32'(tr_busy[24]), 32'd0);
    checkOutput("s4 adc_cnt", 32'(adc_cnt), 32'd3);
    checkOutput("s4 done_cnt", 32'(done_cnt), 32'd0);

    // Scenario 5a: second start edge during integration is ignored.
    applyStimulus(3, 1'b0, 1'b0);
    captureCycles(60, -1, -1, 10);
    analyze(60);
    checkSingleFrame("s5a", 30);

    // Scenario 5b: abort together with a start edge in IDLE.
    applyStimulus(3, 1'b0, 1'b1);
    captureCycles(20, -1, -1, -1);
    analyze(20);
    checkOutput("s5b busy_cnt", 32'(busy_cnt), 32'd0);
    checkOutput("s5b rog_low_cnt", 32'(rog_low_cnt), 32'd0);
    checkOutput("s5b restart_cnt", 32'(rst_cnt), 32'd0);

    // Scenario 6: asynchronous reset in the middle of integration.
    applyStimulus(3, 1'b0, 1'b0);
    captureCycles(10, -1, -1, -1);
    checkOutput("s6 rog_before", 32'(tr_rog[10]), 32'd0);
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("s6 rog_async", 32'(ccd_rog), 32'd1);
    checkOutput("s6 busy_async", 32'(busy), 32'd0);
    checkOutput("s6 clk_async", 32'(ccd_clk), 32'd1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    applyStimulus(3, 1'b0, 1'b0);
    captureCycles(60, -1, -1, -1);
    analyze(60);
    checkSingleFrame("s6", 30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ccd_line_timing_gen.md
Name: ccd_line_timing_gen

Overview:
Parametrised timing generator for linear CCD sensors (ILX511B class and similar). It produces the ROG integration window, the CCD pixel clock and per-pixel ADC start strobes. It sits between the acquisition-control logic (acq_start, integration time) and the ADC capture block.
Over the fixed single-shot ILX511B generator it adds:
- generic pixel count and clock timing
- exact integration tick count
- continuous (free-running) mode
- abort
- pixel index, busy and frame-done outputs

Parameters:
TICK_DIV, 100000, sys_clk cycles per integration tick (1 ms at 100 MHz)
INT_W, 16, width of int_ticks
PIX_COUNT, 2087, ccd_clk periods per readout (includes dummy pixels)
PIX_W, 12, width of pix_idx; 2^PIX_W >= PIX_COUNT
HALF_PER, 8, sys_clk cycles per ccd_clk half-period
ROG_DELAY, 100, sys_clk cycles from ROG rise to first ccd_clk fall
ADC_OFFSET, 4, cycle within the ccd_clk low phase at which adc_start fires; 0 <= ADC_OFFSET < HALF_PER

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
acq_start  in  1  acquisition request, level; rising edge detected internally; synchronous to sys_clk
mode_cont  in  1  1 = continuous frames, 0 = single shot; sampled at each frame end
abort  in  1  synchronous abort, level
int_ticks  in  INT_W  integration time in ticks; latched at each integration start
ccd_rog  out  1  ROG; low during integration, idles high
ccd_clk  out  1  CCD pixel clock; idles high
adc_start  out  1  one-cycle strobe per pixel
pix_idx  out  PIX_W  index of the pixel being strobed; valid when adc_start = 1
adc_restart  out  1  one-cycle pulse at every integration start
frame_done  out  1  one-cycle pulse after the last pixel period
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async assert, synchronous release): state = IDLE, ccd_rog = 1, ccd_clk = 1, adc_start = 0, adc_restart = 0, frame_done = 0, busy = 0, pix_idx = 0, all counters = 0, edge-detect register = 0.
- Start detect: edge = acq_start & ~acq_start_q. In IDLE, an edge moves the FSM to INTEG on the next clock. In that same next cycle: ccd_rog = 0, adc_restart = 1, busy = 1, and int_ticks is latched. A latched value of 0 is treated as 1. Edges while busy are ignored.
- INTEG:
  - tick counter runs 0..TICK_DIV-1; tick count increments on wrap
  - when tick count reaches the latched value, go to ROG_DLY
  - ccd_rog is low for exactly latched × TICK_DIV cycles, then rises
- ROG_DLY: ccd_rog = 1, ccd_clk = 1. After ROG_DELAY cycles, go to READOUT. ccd_clk first falls ROG_DELAY cycles after the ROG rise.
- READOUT:
  - each pixel period = HALF_PER cycles low, then HALF_PER cycles high
  - adc_start pulses on cycle ADC_OFFSET of the low phase (0 = first low cycle), with pix_idx = current pixel
  - pix_idx counts 0..PIX_COUNT-1
  - after the high phase of pixel PIX_COUNT-1: frame_done = 1 for one cycle, pix_idx returns to 0
- Frame end (same cycle as frame_done):
  - mode_cont = 1: go directly to INTEG; ccd_rog falls and adc_restart pulses in the next cycle; int_ticks is re-latched
  - mode_cont = 0: go to IDLE
- Abort: when abort = 1 in any state, the next cycle is IDLE with ccd_rog = 1, ccd_clk = 1, all strobes 0 and counters cleared. No frame_done is issued. Abort takes priority over a start edge in the same cycle and over frame end.
- Reset mid-frame: outputs return to their reset values immediately (asynchronous).
- Counter widths: sized by the team's clog2 helper from TICK_DIV, HALF_PER, ROG_DELAY and PIX_COUNT. No wrap is possible within the legal parameter ranges.
- Outputs are registered; ccd_clk and ccd_rog must be glitch-free.

Test Plan:
All scenarios use TICK_DIV=10, HALF_PER=2, PIX_COUNT=4, ROG_DELAY=3, ADC_OFFSET=1.
1. Single shot, int_ticks = 3, mode_cont = 0, acq_start rises at cycle C → ccd_rog low from C+1 to C+30 (30 cycles); adc_restart pulses at C+1; ccd_clk first falls 3 cycles after ROG rises; 4 adc_start pulses spaced 4 cycles apart with pix_idx 0,1,2,3; one frame_done; busy returns to 0.
2. int_ticks = 0 → ccd_rog low for exactly 10 cycles; readout is otherwise identical to scenario 1.
3. Continuous mode, int_ticks = 2 → frames repeat: 20 low ROG cycles, then 3 delay cycles, then 16 readout cycles. frame_done and adc_restart alternate with no IDLE gap. Clearing mode_cont mid-frame stops the sequence after the current frame.
4. Abort asserted at pix_idx = 2 during readout → next cycle: ccd_clk = 1, ccd_rog = 1, busy = 0; no frame_done and no further adc_start.
5. Second acq_start edge during INTEG, and an abort coinciding with an edge in IDLE → the edge is ignored in the first case; the FSM stays IDLE in the second.
6. sys_rst pulsed asynchronously mid-integration → ccd_rog = 1 and busy = 0 immediately, before the next clock edge; a new start after release behaves as in scenario 1.
